// File: rtl/combo_score_tracker.sv
// combo_score_tracker: BCD score/streak keeper with combo milestone strobe and
// a 4-digit multiplexed 7-segment display of either the score or the streak.
module combo_score_tracker #(
  parameter int STATE_GAME   = 0,
  parameter int STATE_PAUSE  = 1,
  parameter int STATE_RESET  = 2,
  parameter int STATE_BITS   = 1,
  parameter int COMBO_STEP   = 5,
  parameter int MUX_DIV_BITS = 17
) (
  input  logic                  clk,
  input  logic                  Reset_press,
  input  logic [STATE_BITS:0]   game_state,
  input  logic                  display_combo_en,
  input  logic                  hit,
  input  logic                  miss,
  output logic                  combo,
  output logic [15:0]           score_bcd,
  output logic [7:0]            combo_bcd,
  output logic [6:0]            seg,
  output logic [3:0]            an
);
  localparam logic [STATE_BITS:0] GS_GAME  = STATE_GAME[STATE_BITS:0];
  localparam logic [STATE_BITS:0] GS_PAUSE = STATE_PAUSE[STATE_BITS:0];
  localparam logic [STATE_BITS:0] GS_RESET = STATE_RESET[STATE_BITS:0];
  localparam logic [6:0]          STEP     = COMBO_STEP[6:0];

  logic [15:0]             score_q, score_d;
  logic [7:0]              streak_q, streak_d;
  logic [6:0]              shadow_q, shadow_d;
  logic                    combo_q, combo_d;
  logic [MUX_DIV_BITS-1:0] div_q, div_d;
  logic [1:0]              idx_q, idx_d;
  logic [3:0]              an_q, an_d, nib;
  logic [6:0]              seg_q, seg_d;
  logic                    in_game, in_rst;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++)
      if (c) begin
        if (r[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'b1000000;
      4'd1: seg7 = 7'b1111001;
      4'd2: seg7 = 7'b0100100;
      4'd3: seg7 = 7'b0110000;
      4'd4: seg7 = 7'b0011001;
      4'd5: seg7 = 7'b0010010;
      4'd6: seg7 = 7'b0000010;
      4'd7: seg7 = 7'b1111000;
      4'd8: seg7 = 7'b0000000;
      4'd9: seg7 = 7'b0011000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  // Pause and any undefined encoding both fall through to "freeze".
  assign in_game = game_state == GS_GAME && game_state != GS_PAUSE;
  assign in_rst  = game_state == GS_RESET;

  always_comb begin
    score_d  = score_q;
    streak_d = streak_q;
    shadow_d = shadow_q;
    combo_d  = 1'b0;
    if (in_rst) begin
      score_d  = '0;
      streak_d = '0;
      shadow_d = '0;
    end else if (in_game && miss) begin
      streak_d = '0;
      shadow_d = '0;
    end else if (in_game && hit) begin
      score_d = score_q == 16'h9999 ? score_q : bcd_inc(score_q);
      if (shadow_q != 7'd99) begin
        shadow_d = shadow_q + 7'd1;
        streak_d = streak_q[3:0] == 4'd9 ? {streak_q[7:4] + 4'd1, 4'd0}
                                         : {streak_q[7:4], streak_q[3:0] + 4'd1};
        combo_d  = shadow_d % STEP == 7'd0;
      end
    end
  end

  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = &div_q ? idx_q + 2'd1 : idx_q;
    nib   = display_combo_en ? (idx_q[1] ? 4'hf : streak_q[{idx_q[0], 2'b00} +: 4])
                             : score_q[{idx_q, 2'b00} +: 4];
    an_d  = ~(4'b0001 << idx_q);
    seg_d = seg7(nib);
  end

  always_ff @(posedge clk or posedge Reset_press)
    if (Reset_press) begin
      score_q  <= '0;
      streak_q <= '0;
      shadow_q <= '0;
      combo_q  <= 1'b0;
      div_q    <= '0;
      idx_q    <= '0;
      an_q     <= 4'b1110;
      seg_q    <= 7'b1000000;
    end else begin
      score_q  <= score_d;
      streak_q <= streak_d;
      shadow_q <= shadow_d;
      combo_q  <= combo_d;
      div_q    <= div_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end

  assign combo     = combo_q;
  assign score_bcd = score_q;
  assign combo_bcd = streak_q;
  assign an        = an_q;
  assign seg       = seg_q;
endmodule

// File: tb/tb_combo_score_tracker.sv
// tb_combo_score_tracker: scoreboard bench; stimulus queues expectations, a
// negedge monitor pops and compares them against the DUT outputs.
module tb_combo_score_tracker;
  logic       clk = 1'b0;
  logic       Reset_press = 1'b1;
  logic [1:0] game_state = 2'd0;
  logic       display_combo_en = 1'b0, hit = 1'b0, miss = 1'b0;
  logic       combo;
  logic [15:0] score_bcd;
  logic [7:0]  combo_bcd;
  logic [6:0]  seg;
  logic [3:0]  an;

  combo_score_tracker #(.MUX_DIV_BITS(2)) dut (
    .clk(clk), .Reset_press(Reset_press), .game_state(game_state),
    .display_combo_en(display_combo_en), .hit(hit), .miss(miss),
    .combo(combo), .score_bcd(score_bcd), .combo_bcd(combo_bcd),
    .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         kind;
    logic [15:0] s;
    logic [7:0]  c;
    logic [3:0]  an;
    logic [6:0]  seg;
  } snap_t;

  snap_t      snap_q[$];
  logic [7:0] combo_q[$];
  int tests = 0, fails = 0;
  int m_score = 0, m_streak = 0;

  logic [3:0] an_tab[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] sc_seg[4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
  logic [6:0] cb_seg[4] = '{7'b0100100, 7'b1111001, 7'b1111111, 7'b1111111};

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    snap_t s;
    if (combo === 1'b1) begin
      if (combo_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL combo_unexpected: combo=1 with streak %h, required 0", combo_bcd);
      end else chk("combo_streak", {24'd0, combo_bcd}, {24'd0, combo_q.pop_front()});
    end
    if (snap_q.size() > 0) begin
      s = snap_q.pop_front();
      if (s.kind == 3) begin
        tests++;
        fails++;
        $display("FAIL %s: an=%b, required digit-0 window", s.name, an);
      end
      if (s.kind == 0 || s.kind == 2) begin
        chk({s.name, "_score"}, {16'd0, score_bcd}, {16'd0, s.s});
        chk({s.name, "_streak"}, {24'd0, combo_bcd}, {24'd0, s.c});
      end
      if (s.kind == 1 || s.kind == 2) begin
        chk({s.name, "_an"}, {28'd0, an}, {28'd0, s.an});
        chk({s.name, "_seg"}, {25'd0, seg}, {25'd0, s.seg});
      end
      if (s.kind == 2) chk({s.name, "_combo"}, {31'd0, combo}, 32'd0);
    end
  end

  function automatic logic [7:0] bcd8(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit h, input bit m);
    hit = h;
    miss = m;
    tick();
    hit = 1'b0;
    miss = 1'b0;
    if (game_state == 2'd0) begin
      if (m) m_streak = 0;
      else if (h) begin
        if (m_score < 9999) m_score++;
        if (m_streak < 99) begin
          m_streak++;
          if (m_streak % 5 == 0) combo_q.push_back(bcd8(m_streak));
        end
      end
    end
  endtask

  task automatic snap(input string n, input int k, input logic [15:0] s, input logic [7:0] c,
                      input logic [3:0] a, input logic [6:0] sg);
    snap_t e;
    e.name = n; e.kind = k; e.s = s; e.c = c; e.an = a; e.seg = sg;
    snap_q.push_back(e);
  endtask

  task automatic cnt(input string n, input logic [15:0] s, input logic [7:0] c);
    snap(n, 0, s, c, 4'h0, 7'h0);
    tick();
  endtask

  task automatic sreset();
    game_state = 2'd2;
    tick();
    game_state = 2'd0;
    m_score = 0;
    m_streak = 0;
  endtask

  task automatic align();
    logic [3:0] p;
    p = an;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an == 4'b1110 && p == 4'b0111) return;
      p = an;
    end
    snap("align_timeout", 3, 16'h0, 8'h0, 4'h0, 7'h0);
    tick();
  endtask

  task automatic disp_scan(input string n, input bit use_combo);
    align();
    for (int k = 1; k < 16; k++) begin
      tick();
      snap($sformatf("%s%0d", n, k), 1, 16'h0, 8'h0, an_tab[k/4],
           use_combo ? cb_seg[k/4] : sc_seg[k/4]);
    end
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    snap("reset", 2, 16'h0000, 8'h00, 4'b1110, 7'b1000000);
    tick();
    Reset_press = 1'b0;
    tick();

    repeat (7) begin pulse(1, 0); tick(); end
    cnt("seven_hits", 16'h0007, 8'h07);

    sreset();
    repeat (3) pulse(1, 0);
    pulse(0, 1);
    pulse(1, 1);
    repeat (2) pulse(1, 0);
    tick();
    cnt("miss_wins", 16'h0005, 8'h02);

    sreset();
    repeat (9999) pulse(1, 0);
    cnt("preload", 16'h9999, 8'h99);
    pulse(1, 0);
    cnt("saturated", 16'h9999, 8'h99);

    sreset();
    repeat (4) pulse(1, 0);
    game_state = 2'd1;
    repeat (3) pulse(1, 0);
    cnt("paused", 16'h0004, 8'h04);
    game_state = 2'd3;
    pulse(1, 0);
    cnt("undef_state", 16'h0004, 8'h04);
    sreset();
    cnt("state_reset", 16'h0000, 8'h00);
    pulse(1, 0);
    cnt("resume", 16'h0001, 8'h01);

    sreset();
    repeat (1222) pulse(1, 0);
    pulse(0, 1);
    repeat (12) pulse(1, 0);
    tick();
    cnt("disp_setup", 16'h1234, 8'h12);
    disp_scan("score_digit", 1'b0);
    display_combo_en = 1'b1;
    disp_scan("combo_digit", 1'b1);
    display_combo_en = 1'b0;

    sreset();
    repeat (4) pulse(1, 0);
    hit = 1'b1;
    tick();
    hit = 1'b0;
    #1;
    Reset_press = 1'b1;
    snap("async_reset", 2, 16'h0000, 8'h00, 4'b1110, 7'b1000000);
    tick();
    Reset_press = 1'b0;
    m_score = 0;
    m_streak = 0;
    tick();
    pulse(1, 0);
    tick();
    cnt("after_reset", 16'h0001, 8'h01);

    repeat (3) tick();
    chk("combo_queue_drained", combo_q.size(), 0);
    chk("snap_queue_drained", snap_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
